// File: rtl/halton_sample_scheduler.sv
// Pairs base-2 (X) and base-3 (Y) Halton generator streams into 2D points behind a small FIFO.
// Optional SKIP_ORIGIN_EN drops the (0,0) pair and requests N+1 generator values.
module halton_sample_scheduler #(
    parameter int  MAP_WIDTH  = 1000,
    parameter int  FIFO_DEPTH = 4,
    localparam int VAL_W      = $clog2(MAP_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [15:0]      num_points_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             gen_clr_o,
    output logic [15:0]      gen_num_o,
    output logic [1:0]       genx_base_o,
    output logic [1:0]       geny_base_o,
    output logic             genx_en_o,
    output logic             geny_en_o,
    input  logic [VAL_W-1:0] genx_value_i,
    input  logic [VAL_W-1:0] geny_value_i,
    input  logic [15:0]      genx_index_i,
    input  logic [15:0]      geny_index_i,
    input  logic             genx_valid_i,
    input  logic             geny_valid_i,
    output logic [VAL_W-1:0] point_x_o,
    output logic [VAL_W-1:0] point_y_o,
    output logic [15:0]      point_idx_o,
    output logic             point_valid_o,
    input  logic             point_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [15:0]      n_q;
    logic [15:0]      pair_cnt;
    logic [15:0]      gen_num_q;
    logic [15:0]      gen_num_nx;
    logic             err_q;

    logic             xf, yf;
    logic [VAL_W-1:0] xv, yv;
    logic [15:0]      xi, yi;

    logic [VAL_W-1:0] fx [FIFO_DEPTH];
    logic [VAL_W-1:0] fy [FIFO_DEPTH];
    logic [15:0]      fi [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] occ;

    logic start_ok;
    logic pair_full;
    logic match;
    logic skip;
    logic mism;
    logic push;
    logic pop;
    logic run_on;
    logic room;
    logic capx, capy;

    assign start_ok  = (state == S_IDLE) && start_i;
    assign pair_full = (state == S_RUN) && xf && yf;
    assign match     = pair_full && (xi == yi);
    assign mism      = pair_full && (xi != yi);

`ifdef SKIP_ORIGIN_EN
    assign skip       = match && (xi == 16'd0);
    assign gen_num_nx = (num_points_i == 16'hFFFF) ? 16'hFFFF
                                                   : num_points_i + 16'd1;
`else
    assign skip       = 1'b0;
    assign gen_num_nx = num_points_i;
`endif

    assign push = match && !skip;
    assign pop  = point_valid_o && point_ready_i;

    // A complete pair waiting to be pushed already owns a FIFO slot
    assign occ    = fifo_cnt + CNT_W'(pair_full);
    assign room   = occ < CNT_W'(FIFO_DEPTH);
    assign run_on = (state == S_RUN) && (pair_cnt != n_q);

    assign genx_en_o = run_on && !xf && room;
    assign geny_en_o = run_on && !yf && room;
    assign capx      = genx_valid_i && genx_en_o;
    assign capy      = geny_valid_i && geny_en_o;

    assign busy_o        = (state != S_IDLE);
    assign done_o        = (state == S_DONE);
    assign gen_clr_o     = (state == S_CLEAR);
    assign err_o         = err_q;
    assign gen_num_o     = gen_num_q;
    assign genx_base_o   = 2'd2;
    assign geny_base_o   = 2'd3;
    assign point_valid_o = (fifo_cnt != '0);
    assign point_x_o     = fx[rptr];
    assign point_y_o     = fy[rptr];
    assign point_idx_o   = fi[rptr];

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start_i) state_nx = S_CLEAR;
            S_CLEAR: state_nx = (n_q == 16'd0) ? S_DONE : S_RUN;
            S_RUN:   if (pair_cnt == n_q) state_nx = S_DRAIN;
            S_DRAIN: if (fifo_cnt == '0) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            n_q       <= '0;
            gen_num_q <= '0;
            err_q     <= 1'b0;
            pair_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                n_q       <= num_points_i;
                gen_num_q <= gen_num_nx;
                err_q     <= 1'b0;
            end else if (mism) begin
                err_q <= 1'b1;
            end
            if (state == S_CLEAR) pair_cnt <= '0;
            else if (push) pair_cnt <= pair_cnt + 16'd1;
        end
    end

    // Mismatched pair: the lower index can never find a partner, so it goes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xf <= 1'b0;
            yf <= 1'b0;
            xv <= '0;
            yv <= '0;
            xi <= '0;
            yi <= '0;
        end else if (state == S_CLEAR) begin
            xf <= 1'b0;
            yf <= 1'b0;
        end else begin
            if (match) begin
                xf <= 1'b0;
                yf <= 1'b0;
            end else if (mism) begin
                if (xi < yi) xf <= 1'b0;
                else yf <= 1'b0;
            end
            if (capx) begin
                xf <= 1'b1;
                xv <= genx_value_i;
                xi <= genx_index_i;
            end
            if (capy) begin
                yf <= 1'b1;
                yv <= geny_value_i;
                yi <= geny_index_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fx[i] <= '0;
                fy[i] <= '0;
                fi[i] <= '0;
            end
        end else begin
            if (push) begin
                fx[wptr] <= xv;
                fy[wptr] <= yv;
                fi[wptr] <= xi;
                wptr     <= wptr + PTR_W'(1);
            end
            if (pop) rptr <= rptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_halton_sample_scheduler.sv
// Bench for halton_sample_scheduler: behavioural Halton generators plus a
// stream-merge reference model of the expected point sequence.
module tb_halton_sample_scheduler;

    localparam int MW = 1000;
    localparam int FD = 4;
    localparam int VW = $clog2(MW + 1);

`ifdef SKIP_ORIGIN_EN
    localparam bit SKIP = 1'b1;
    localparam int LIT [3][3] = '{'{500, 333, 1}, '{250, 666, 2}, '{750, 111, 3}};
`else
    localparam bit SKIP = 1'b0;
    localparam int LIT [3][3] = '{'{0, 0, 0}, '{500, 333, 1}, '{250, 666, 2}};
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_i = 1'b0;
    logic [15:0]   num_points_i = '0;
    logic          busy_o, done_o, err_o, gen_clr_o;
    logic [15:0]   gen_num_o;
    logic [1:0]    genx_base_o, geny_base_o;
    logic          genx_en_o, geny_en_o;
    logic [VW-1:0] genx_value_i, geny_value_i;
    logic [15:0]   genx_index_i, geny_index_i;
    logic          genx_valid_i, geny_valid_i;
    logic [VW-1:0] point_x_o, point_y_o;
    logic [15:0]   point_idx_o;
    logic          point_valid_o;
    logic          point_ready_i = 1'b1;

    always #5 clk = ~clk;

    halton_sample_scheduler #(.MAP_WIDTH(MW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset),
        .start_i(start_i), .num_points_i(num_points_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .gen_clr_o(gen_clr_o), .gen_num_o(gen_num_o),
        .genx_base_o(genx_base_o), .geny_base_o(geny_base_o),
        .genx_en_o(genx_en_o), .geny_en_o(geny_en_o),
        .genx_value_i(genx_value_i), .geny_value_i(geny_value_i),
        .genx_index_i(genx_index_i), .geny_index_i(geny_index_i),
        .genx_valid_i(genx_valid_i), .geny_valid_i(geny_valid_i),
        .point_x_o(point_x_o), .point_y_o(point_y_o),
        .point_idx_o(point_idx_o), .point_valid_o(point_valid_o),
        .point_ready_i(point_ready_i)
    );

    typedef struct {
        int x;
        int y;
        int idx;
    } pt_t;

    pt_t expq[$];
    pt_t got[$];
    bit  exp_err;
    int  checks = 0;
    int  errors = 0;
    int  valid_seen = 0;
    int  gxc = 0, gyc = 0;
    int  inj_at = -1;
    int  bub_pct = 0;

    // Radical inverse of idx in base b, scaled to the map side
    function automatic int hv(input int idx, input int b);
        longint num = 0;
        longint den = 1;
        int i = idx;
        while (i > 0) begin
            num = num * b + (i % b);
            den = den * b;
            i = i / b;
        end
        return int'((num * MW) / den);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected output: merge X stream (k, hx(k)) with Y stream, where the
    // Y entry at position inj carries index inj+1; equal heads pair up,
    // otherwise the lower index is dropped and an error is recorded.
    task automatic build(input int n, input int inj);
        int ax = 0, ay = 0, cnt = 0, xi, yi;
        pt_t p;
        expq.delete();
        exp_err = 1'b0;
        while (cnt < n) begin
            xi = ax;
            yi = (ay == inj) ? ay + 1 : ay;
            if (xi == yi) begin
                if (!(SKIP && xi == 0)) begin
                    p.x = hv(ax, 2);
                    p.y = hv(ay, 3);
                    p.idx = xi;
                    expq.push_back(p);
                    cnt++;
                end
                ax++;
                ay++;
            end else begin
                exp_err = 1'b1;
                if (xi < yi) ax++;
                else ay++;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            gxc <= 0;
            genx_valid_i <= 1'b0;
            genx_value_i <= '0;
            genx_index_i <= '0;
        end else if (gen_clr_o) begin
            gxc <= 0;
            genx_valid_i <= 1'b0;
        end else if (genx_en_o) begin
            if ($urandom_range(99) < bub_pct) begin
                genx_valid_i <= 1'b0;
            end else begin
                genx_valid_i <= 1'b1;
                genx_index_i <= 16'(gxc);
                genx_value_i <= VW'(hv(gxc, 2));
                gxc <= gxc + 1;
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            gyc <= 0;
            geny_valid_i <= 1'b0;
            geny_value_i <= '0;
            geny_index_i <= '0;
        end else if (gen_clr_o) begin
            gyc <= 0;
            geny_valid_i <= 1'b0;
        end else if (geny_en_o) begin
            if ($urandom_range(99) < bub_pct) begin
                geny_valid_i <= 1'b0;
            end else begin
                geny_valid_i <= 1'b1;
                geny_index_i <= 16'((gyc == inj_at) ? gyc + 1 : gyc);
                geny_value_i <= VW'(hv(gyc, 3));
                gyc <= gyc + 1;
            end
        end
    end

    bit  hold_chk = 1'b0;
    pt_t held;

    always @(negedge clk) begin
        pt_t e, g;
        if (!reset) begin
            hold_chk = 1'b0;
        end else begin
            if (point_valid_o) valid_seen++;
            if (hold_chk) begin
                chk("hold_valid", point_valid_o, 1);
                chk("hold_x", point_x_o, held.x);
                chk("hold_y", point_y_o, held.y);
                chk("hold_idx", point_idx_o, held.idx);
            end
            if (point_valid_o && point_ready_i) begin
                g.x = int'(point_x_o);
                g.y = int'(point_y_o);
                g.idx = int'(point_idx_o);
                got.push_back(g);
                if (expq.size() == 0) begin
                    chk("unexpected_point", point_idx_o, -1);
                end else begin
                    e = expq.pop_front();
                    chk("pt_x", g.x, e.x);
                    chk("pt_y", g.y, e.y);
                    chk("pt_idx", g.idx, e.idx);
                end
            end
            hold_chk = point_valid_o && !point_ready_i;
            held.x = int'(point_x_o);
            held.y = int'(point_y_o);
            held.idx = int'(point_idx_o);
        end
    end

    task automatic run(input int n, input int inj, input int rdy,
                       input int bub, input bit mid, input int stall);
        int dones = 0;
        int cyc = 0;
        int gn = n;
        if (SKIP) gn = (n >= 65535) ? 65535 : n + 1;
        inj_at = inj;
        bub_pct = bub;
        build(n, inj);
        valid_seen = 0;
        got.delete();
        @(posedge clk); #1;
        start_i = 1'b1;
        num_points_i = 16'(n);
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("gen_num", gen_num_o, gn);
        chk("err_cleared", err_o, 0);
        chk("busy_after_start", busy_o, 1);
        while (busy_o && cyc < 4000) begin
            if (cyc < stall) point_ready_i = 1'b0;
            else point_ready_i = ($urandom_range(99) < rdy);
            start_i = mid && (cyc == 5);
            num_points_i = 16'(n + 5);
            if (stall > 0 && cyc == stall - 1) begin
                chk("full_genx_en", genx_en_o, 0);
                chk("full_geny_en", geny_en_o, 0);
                chk("full_valid", point_valid_o, 1);
                chk("full_count", dut.fifo_cnt, FD);
            end
            @(posedge clk); #1;
            cyc++;
            if (done_o) dones++;
        end
        start_i = 1'b0;
        point_ready_i = 1'b1;
        chk("run_finished", busy_o, 0);
        chk("done_pulses", dones, 1);
        chk("done_low_idle", done_o, 0);
        chk("err_final", err_o, exp_err);
        chk("points_left", expq.size(), 0);
        if (n == 0) chk("zero_no_valid", valid_seen, 0);
        if (mid) chk("gen_num_kept", gen_num_o, gn);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, inj, cyc;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_clr", gen_clr_o, 0);
        chk("rst_gen_num", gen_num_o, 0);
        chk("rst_base_x", genx_base_o, 2);
        chk("rst_base_y", geny_base_o, 3);
        chk("rst_en_x", genx_en_o, 0);
        chk("rst_en_y", geny_en_o, 0);
        chk("rst_valid", point_valid_o, 0);
        chk("rst_pt", {point_x_o, point_y_o, point_idx_o}, 0);
        #20;
        @(negedge clk);
        reset = 1'b1;

        run(3, -1, 100, 0, 1'b0, 0);
        chk("basic_count", got.size(), 3);
        if (got.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("lit_x", got[i].x, LIT[i][0]);
                chk("lit_y", got[i].y, LIT[i][1]);
                chk("lit_idx", got[i].idx, LIT[i][2]);
            end
        end

        run(8, -1, 100, 0, 1'b0, 60);
        chk("bp_count", got.size(), 8);

        run(4, 2, 100, 0, 1'b0, 0);
        run(2, -1, 100, 0, 1'b0, 0);
        run(0, -1, 100, 0, 1'b0, 0);
        run(6, -1, 70, 20, 1'b1, 0);

        inj_at = -1;
        bub_pct = 0;
        build(10, -1);
        got.delete();
        @(posedge clk); #1;
        start_i = 1'b1;
        num_points_i = 16'd10;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0;
        while (got.size() < 2 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("pre_reset_points", got.size(), 2);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_valid", point_valid_o, 0);
        chk("mid_rst_count", dut.fifo_cnt, 0);
        expq.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        run(2, -1, 100, 0, 1'b0, 0);
        chk("post_rst_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("post_rst_idx0", got[0].idx, SKIP ? 1 : 0);
            chk("post_rst_idx1", got[1].idx, SKIP ? 2 : 1);
        end

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(12, 1);
            inj = -1;
            if (n >= 3 && $urandom_range(1) == 1) inj = $urandom_range(n - 2, 1);
            run(n, inj, $urandom_range(100, 30), $urandom_range(40), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
